spi_master: RTL and testbench

- Mode-0 SPI master: the initiator end of the 8-bit serial link whose target side is the slave block already in the design.
- Takes a parallel byte and a start strobe from the system clock domain, then drives cs, sclk and mosi.
- Shifts in miso at the same time and returns the received byte with a one-cycle done pulse.
- Everything runs on one system clock; sclk is a divided, registered output.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 47 ++++
 rtl/spi_master.sv | 126 ++++++++++++
 tb/tb_spi_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, default frame width
// and the fixed bus mode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_t;

  localparam int unsigned DEFAULT_DATA_W = 8;

  // Mode 0: sclk idles low, data sampled on the leading (rising) edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter that produces the registered sclk and same-cycle
// strobes announcing the edge sclk is about to take.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  input  logic rise_ok,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick,
  output logic half_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Strobes are decoded from registered state so the caller can update its
  // own registers on the very edge that moves sclk.
  always_comb begin
    half_tick = en && !clr && (cnt == LAST);
    rise_tick = half_tick && !sclk && rise_ok;
    fall_tick = half_tick && sclk;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      sclk <= SPI_CPOL;
    end else if (clr) begin
      cnt  <= '0;
      sclk <= SPI_CPOL;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
      if (rise_tick)      sclk <= 1'b1;
      else if (fall_tick) sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: serialises one frame per accepted start, MSB first,
// capturing miso in parallel and reporting the received word with done.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam int unsigned GW = $clog2(CS_GAP + 1);
  localparam logic [BW-1:0] BITS     = BW'(DATA_W);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  spi_state_t        state;
  logic [DATA_W-2:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;

  logic rise_tick, fall_tick, half_tick, rise_ok;
  logic sample_tick, launch_tick;

  always_comb begin
    rise_ok     = (state == SETUP) || ((state == SHIFT) && (bit_cnt != BITS));
    sample_tick = SPI_CPHA ? fall_tick : rise_tick;
    launch_tick = SPI_CPHA ? rise_tick : fall_tick;
  end

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state != IDLE),
    .clr      (state == IDLE),
    .rise_ok  (rise_ok),
    .sclk     (sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .half_tick(half_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // MSB goes straight to mosi; tx_sh keeps only the bits still to send.
            tx_sh   <= tx_data[DATA_W-2:0];
            mosi    <= tx_data[DATA_W-1];
            rx_sh   <= '0;
            bit_cnt <= '0;
            cs      <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (sample_tick) begin
            rx_sh   <= {rx_sh[DATA_W-2:0], miso};
            bit_cnt <= bit_cnt + BW'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sample_tick) begin
            rx_sh   <= {rx_sh[DATA_W-2:0], miso};
            bit_cnt <= bit_cnt + BW'(1);
          end else if (launch_tick) begin
            if (bit_cnt != BITS) begin
              mosi  <= tx_sh[DATA_W-2];
              tx_sh <= {tx_sh[DATA_W-3:0], 1'b0};
            end else begin
              mosi  <= 1'b0;
            end
          end else if (half_tick && (bit_cnt == BITS)) begin
            // Trailing low half-period has elapsed: release cs and report.
            cs      <= 1'b1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (half_tick) begin
            if (gap_cnt == GAP_LAST) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback and slave-model frames,
// ignored starts, back-to-back frames, mid-frame reset and CLK_DIV=1.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] tx_data;
  logic       busy, done, cs, sclk, mosi, miso;
  logic [7:0] rx_data;

  logic       start1;
  logic [7:0] tx1;
  logic       busy1, done1, cs1, sclk1, mosi1;
  logic [7:0] rx1;

  logic       sel_slave = 1'b0;
  logic [7:0] sl_din = 8'h00;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic       sl_cs_q = 1'b1;
  logic       sl_sclk_q = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got1_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign miso = sel_slave ? sl_sh[7] : mosi;

  spi_master #(.CLK_DIV(4), .DATA_W(8), .CS_GAP(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .cs(cs), .sclk(sclk),
    .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(1), .DATA_W(8), .CS_GAP(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1), .cs(cs1), .sclk(sclk1),
    .mosi(mosi1), .miso(mosi1)
  );

  // Mode-0 slave model: loads on cs fall, samples mosi on sclk rise, shifts on fall.
  always @(posedge clk) begin
    sl_cs_q   <= cs;
    sl_sclk_q <= sclk;
    if (sl_cs_q && !cs)                 sl_sh <= sl_din;
    else if (!cs && sl_sclk_q && !sclk) sl_sh <= {sl_sh[6:0], 1'b0};
    if (!cs && !sl_sclk_q && sclk)      sl_rx <= {sl_rx[6:0], mosi};
  end

  task automatic run_frame(input logic [7:0] tx, input bit glitch, input int nsamp,
                           output int done_cnt, output int done_at, output int cs_low,
                           output int rises, output int bad_period, output int mosi_bad);
    logic prev_sclk, prev_mosi;
    int   last_rise;
    done_cnt = 0; done_at = 0; cs_low = 0; rises = 0; bad_period = 0; mosi_bad = 0;
    last_rise = 0;
    @(negedge clk);
    prev_sclk = sclk;
    prev_mosi = mosi;
    start = 1'b1;
    tx_data = tx;
    for (int i = 1; i <= nsamp; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (glitch && i == 30) begin start = 1'b1; tx_data = 8'hFF; end
      if (glitch && i == 31) start = 1'b0;
      if (!cs) cs_low++;
      if (sclk && !prev_sclk) begin
        rises++;
        if (last_rise > 0 && (i - last_rise) != 8) bad_period++;
        last_rise = i;
      end
      if (mosi !== prev_mosi && sclk !== 1'b0) mosi_bad++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_at = i;
        got_q.push_back(rx_data);
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; tx_data = 8'h00; start1 = 1'b0; tx1 = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cs, sclk, mosi, busy, done, rx_data} !== {5'b10000, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_dut: {cs,sclk,mosi,busy,done,rx}=%b expected %b",
               {cs, sclk, mosi, busy, done, rx_data}, {5'b10000, 8'h00});
    end
    n_cmp++;
    if ({cs1, sclk1, mosi1, busy1, done1, rx1} !== {5'b10000, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_dut1: {cs,sclk,mosi,busy,done,rx}=%b expected %b",
               {cs1, sclk1, mosi1, busy1, done1, rx1}, {5'b10000, 8'h00});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    int dc, da, cl, rs, bp, mb;
    logic [7:0] e, g;
    sel_slave = 1'b0;
    exp_q.push_back(8'hA5);
    run_frame(8'hA5, 1'b0, 100, dc, da, cl, rs, bp, mb);
    n_cmp++; if (dc !== 1)  begin n_bad++; $display("FAIL loop_done_count: got %0d expected 1", dc); end
    n_cmp++; if (da !== 69) begin n_bad++; $display("FAIL loop_start_to_done: got %0d expected 69", da); end
    n_cmp++; if (cl !== 68) begin n_bad++; $display("FAIL loop_cs_low: got %0d expected 68", cl); end
    n_cmp++; if (rs !== 8)  begin n_bad++; $display("FAIL loop_sclk_pulses: got %0d expected 8", rs); end
    n_cmp++; if (bp !== 0)  begin n_bad++; $display("FAIL loop_sclk_period: %0d periods not 8, expected 0", bp); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL loop_sb_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL loop_rx: got %02h expected %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL loop_rx_hold: got %02h expected a5", rx_data); end
  endtask

  task automatic test_slave();
    int dc, da, cl, rs, bp, mb;
    logic [7:0] e, g;
    sel_slave = 1'b1;
    sl_din = 8'h3C;
    exp_q.push_back(8'h3C);
    run_frame(8'hC3, 1'b0, 100, dc, da, cl, rs, bp, mb);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL slave_done_count: got %0d expected 1", dc); end
    n_cmp++; if (mb !== 0) begin n_bad++; $display("FAIL slave_mosi_while_sclk_high: %0d changes expected 0", mb); end
    n_cmp++; if (sl_rx !== 8'hC3) begin n_bad++; $display("FAIL slave_dout: got %02h expected c3", sl_rx); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL slave_sb_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL slave_rx: got %02h expected %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    sel_slave = 1'b0;
  endtask

  task automatic test_ignore_start();
    int dc, da, cl, rs, bp, mb;
    logic [7:0] e, g;
    exp_q.push_back(8'h33);
    run_frame(8'h33, 1'b1, 100, dc, da, cl, rs, bp, mb);
    n_cmp++; if (dc !== 1)  begin n_bad++; $display("FAIL ignore_done_count: got %0d expected 1", dc); end
    n_cmp++; if (cl !== 68) begin n_bad++; $display("FAIL ignore_cs_low: got %0d expected 68", cl); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL ignore_sb_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ignore_rx: got %02h expected %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int dc = 0;
    int gap_run = 0;
    bit seen_idle = 0;
    logic [7:0] e, g;
    @(negedge clk);
    start = 1'b1;
    tx_data = 8'h01;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 5) tx_data = 8'h80;
      if (done) begin dc++; got_q.push_back(rx_data); end
      if (dc == 1 && cs) gap_run++;
      if (dc >= 1 && !busy) seen_idle = 1;
      if (seen_idle && busy) start = 1'b0;
    end
    start = 1'b0;
    n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", dc); end
    n_cmp++; if (gap_run < 8) begin n_bad++; $display("FAIL b2b_cs_gap: got %0d cycles expected >=8", gap_run); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL b2b_sb_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_rx: got %02h expected %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int dc = 0;
    int fdc, da, cl, rs, bp, mb;
    logic [7:0] e, g;
    @(negedge clk);
    start = 1'b1;
    tx_data = 8'hA5;
    for (int i = 1; i <= 39; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) dc++;
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cs, sclk, busy, done, mosi, rx_data} !== {5'b10000, 8'h00}) begin
      n_bad++;
      $display("FAIL midreset_outputs: {cs,sclk,busy,done,mosi,rx}=%b expected %b",
               {cs, sclk, busy, done, mosi, rx_data}, {5'b10000, 8'h00});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dc); end
    exp_q.push_back(8'h5A);
    run_frame(8'h5A, 1'b0, 100, fdc, da, cl, rs, bp, mb);
    n_cmp++; if (fdc !== 1) begin n_bad++; $display("FAIL midreset_next_done: got %0d expected 1", fdc); end
    n_cmp++; if (cl !== 68) begin n_bad++; $display("FAIL midreset_next_cs_low: got %0d expected 68", cl); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL midreset_sb_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL midreset_rx: got %02h expected %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_clkdiv1();
    int cl = 0, tg = 0, dc = 0, da = 0;
    logic prev;
    logic [7:0] e, g;
    @(negedge clk);
    prev = sclk1;
    start1 = 1'b1;
    tx1 = 8'h96;
    exp1_q.push_back(8'h96);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start1 = 1'b0;
      if (!cs1) cl++;
      if (!cs1 && sclk1 !== prev) tg++;
      if (done1) begin dc++; if (dc == 1) da = i; got1_q.push_back(rx1); end
      prev = sclk1;
    end
    n_cmp++; if (cl !== 17) begin n_bad++; $display("FAIL div1_cs_low: got %0d expected 17", cl); end
    n_cmp++; if (tg !== 16) begin n_bad++; $display("FAIL div1_sclk_toggles: got %0d expected 16", tg); end
    n_cmp++; if (dc !== 1)  begin n_bad++; $display("FAIL div1_done_count: got %0d expected 1", dc); end
    n_cmp++; if (da !== 18) begin n_bad++; $display("FAIL div1_start_to_done: got %0d expected 18", da); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL div1_busy_end: got %b expected 0", busy1); end
    n_cmp++;
    if (got1_q.size() != exp1_q.size()) begin
      n_bad++; $display("FAIL div1_sb_count: got %0d results expected %0d", got1_q.size(), exp1_q.size());
    end
    while (got1_q.size() > 0 && exp1_q.size() > 0) begin
      g = got1_q.pop_front(); e = exp1_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL div1_rx: got %02h expected %02h", g, e); end
    end
    got1_q.delete(); exp1_q.delete();
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
